// File: rtl/pl_ps_mailbox.sv
// pl_ps_mailbox
//   Register-mapped mailbox between the PS-side register slave and the PL
//   solver datapath. Command words that the PS writes to TXDATA are queued in
//   a TX FIFO. The FIFO head is offered to PL logic as a valid/ready stream.
//   Result words from PL logic are queued in an RX FIFO. The PS drains that
//   FIFO by reading RXDATA.
//
// Ports
//   ACLK, ARESET        clock (rising edge), asynchronous active-high reset
//   reg_wr_*            single-cycle register write strobe, byte address, data
//   reg_rd_en/addr      single-cycle register read strobe, byte address
//   reg_rd_data/valid   read response, one cycle after reg_rd_en
//   m_valid/ready/data  TX stream toward PL logic (FIFO head)
//   s_valid/ready/data  RX stream from PL logic
//   irq                 registered level interrupt: irq_en & ~rx_empty
//
// Register map (index = addr[3:2])
//   0 TXDATA  write pushes to the TX FIFO. Reads return 0.
//   1 RXDATA  read pops the RX FIFO. Writes are ignored.
//   2 STATUS  [0] tx_empty [1] tx_full [2] rx_empty [3] rx_full
//             [4] tx_ovf, W1C, sticky  [5] rx_udf, W1C, sticky
//             [15:8] tx_count [23:16] rx_count
//   3 CTRL    [0] tx_flush [1] rx_flush (self-clearing, read 0) [2] irq_en
//
// Handshake: a stream beat transfers on the rising edge where valid and
// ready are both high. While valid is high it stays high, and the data
// holds stable, until that beat transfers.

module pl_ps_mailbox #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              reg_wr_en,
    input  logic [3:0]        reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    input  logic              reg_rd_en,
    input  logic [3:0]        reg_rd_addr,
    output logic [DATA_W-1:0] reg_rd_data,
    output logic              reg_rd_valid,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]     tx_mem [DEPTH];
    logic [DATA_W-1:0]     rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CNT_W-1:0]      tx_count, rx_count;
    logic                  tx_ovf, rx_udf, irq_en;

    logic [1:0] wr_idx, rd_idx;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       tx_wr_req, rx_rd_req, tx_flush, rx_flush;
    logic       tx_hs, tx_push, tx_pop, rx_push, rx_pop;
    logic       tx_ovf_set, rx_udf_set, ovf_clr, udf_clr;
    logic [31:0]       status_word;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_addr_bits;

    assign wr_idx = reg_wr_addr[3:2];
    assign rd_idx = reg_rd_addr[3:2];
    // Byte-lane address bits carry no meaning for 32-bit registers.
    assign unused_addr_bits = ^{reg_wr_addr[1:0], reg_rd_addr[1:0]};

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CNT_FULL);
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_FULL);

    assign m_valid = ~tx_empty;
    assign m_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
    assign s_ready = ~rx_full;

    assign tx_wr_req = reg_wr_en & (wr_idx == 2'd0);
    assign rx_rd_req = reg_rd_en & (rd_idx == 2'd1);
    assign tx_flush  = reg_wr_en & (wr_idx == 2'd3) & reg_wr_data[0];
    assign rx_flush  = reg_wr_en & (wr_idx == 2'd3) & reg_wr_data[1];
    assign ovf_clr   = reg_wr_en & (wr_idx == 2'd2) & reg_wr_data[4];
    assign udf_clr   = reg_wr_en & (wr_idx == 2'd2) & reg_wr_data[5];

    // A write to a full TX FIFO still fits when the stream pops in the same
    // cycle. A flush discards every push and pop to that FIFO and raises no flags.
    assign tx_hs      = m_valid & m_ready;
    assign tx_pop     = tx_hs & ~tx_flush;
    assign tx_push    = tx_wr_req & (~tx_full | tx_hs) & ~tx_flush;
    assign tx_ovf_set = tx_wr_req & tx_full & ~tx_hs & ~tx_flush;

    assign rx_push    = s_valid & s_ready & ~rx_flush;
    assign rx_pop     = rx_rd_req & ~rx_empty & ~rx_flush;
    assign rx_udf_set = rx_rd_req & rx_empty & ~rx_flush;

    always_comb begin
        status_word        = '0;
        status_word[0]     = tx_empty;
        status_word[1]     = tx_full;
        status_word[2]     = rx_empty;
        status_word[3]     = rx_full;
        status_word[4]     = tx_ovf;
        status_word[5]     = rx_udf;
        status_word[15:8]  = 8'(tx_count);
        status_word[23:16] = 8'(rx_count);
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            2'd1:    rd_mux = rx_empty ? '0 : rx_mem[rx_rd_ptr];
            2'd2:    rd_mux = DATA_W'(status_word);
            2'd3:    rd_mux = DATA_W'({irq_en, 2'b00});
            default: rd_mux = '0;
        endcase
    end

    // Storage is not reset. Words beyond the count are never observed.
    always_ff @(posedge ACLK) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= reg_wr_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= s_data;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_count     <= '0;
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_count     <= '0;
            tx_ovf       <= 1'b0;
            rx_udf       <= 1'b0;
            irq_en       <= 1'b0;
            irq          <= 1'b0;
            reg_rd_valid <= 1'b0;
            reg_rd_data  <= '0;
        end else begin
            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                tx_count  <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
                case ({tx_push, tx_pop})
                    2'b10:   tx_count <= tx_count + CNT_ONE;
                    2'b01:   tx_count <= tx_count - CNT_ONE;
                    default: tx_count <= tx_count;
                endcase
            end

            if (rx_flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                rx_count  <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
                case ({rx_push, rx_pop})
                    2'b10:   rx_count <= rx_count + CNT_ONE;
                    2'b01:   rx_count <= rx_count - CNT_ONE;
                    default: rx_count <= rx_count;
                endcase
            end

            // A set event beats a W1C clear in the same cycle.
            tx_ovf <= tx_ovf_set | (tx_ovf & ~ovf_clr);
            rx_udf <= rx_udf_set | (rx_udf & ~udf_clr);

            if (reg_wr_en && wr_idx == 2'd3) irq_en <= reg_wr_data[2];

            irq          <= irq_en & ~rx_empty;
            reg_rd_valid <= reg_rd_en;
            reg_rd_data  <= reg_rd_en ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_pl_ps_mailbox.sv
// Directed bench for pl_ps_mailbox. Inputs change on the falling edge.
// Outputs are sampled on the falling edge, away from the active rising edge.

module tb_pl_ps_mailbox;

    localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h4, A_ST = 4'h8, A_CT = 4'hC;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        reg_wr_en, reg_rd_en, m_ready, s_valid;
    logic [3:0]  reg_wr_addr, reg_rd_addr;
    logic [31:0] reg_wr_data, s_data;
    logic [31:0] reg_rd_data, m_data;
    logic        reg_rd_valid, m_valid, s_ready, irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] d;

    always #5 ACLK = ~ACLK;

    pl_ps_mailbox #(.DATA_W(32), .DEPTH_LOG2(2)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic reg_write(input logic [3:0] a, input logic [31:0] v);
        reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = v;
        @(negedge ACLK);
        reg_wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] v);
        reg_rd_en = 1'b1; reg_rd_addr = a;
        @(negedge ACLK);
        reg_rd_en = 1'b0;
        chk("rd_valid", {31'b0, reg_rd_valid}, 32'd1);
        v = reg_rd_data;
    endtask

    initial begin
        ARESET = 1'b1;
        reg_wr_en = 0; reg_wr_addr = 0; reg_wr_data = 0;
        reg_rd_en = 0; reg_rd_addr = 0;
        m_ready = 0; s_valid = 0; s_data = 0;
        repeat (3) @(negedge ACLK);

        // Reset state
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_rd_valid", {31'b0, reg_rd_valid}, 32'd0);
        chk("rst_rd_data", reg_rd_data, 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        reg_read(A_ST, d); chk("status_after_reset", d, 32'h0000_0005);

        // Fill TX with m_ready low, then drain
        for (int i = 1; i <= 4; i++) reg_write(A_TX, 32'(i));
        chk("tx_head_valid", {31'b0, m_valid}, 32'd1);
        chk("tx_head_data", m_data, 32'd1);
        reg_read(A_ST, d); chk("status_tx_full", d, 32'h0000_0406);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("tx_drain_valid", {31'b0, m_valid}, 32'd1);
            chk("tx_drain_data", m_data, 32'(i));
            @(negedge ACLK);
        end
        m_ready = 1'b0;
        chk("tx_empty_valid", {31'b0, m_valid}, 32'd0);
        chk("tx_empty_data", m_data, 32'd0);
        reg_read(A_ST, d); chk("status_tx_drained", d, 32'h0000_0005);

        // Overflow on a full FIFO, then W1C clear
        for (int i = 0; i < 4; i++) reg_write(A_TX, 32'h11 + 32'(i));
        reg_write(A_TX, 32'h5);
        reg_read(A_ST, d); chk("status_tx_ovf", d, 32'h0000_0416);
        chk("tx_head_stable", m_data, 32'h11);
        reg_write(A_ST, 32'h10);
        reg_read(A_ST, d); chk("status_ovf_cleared", d, 32'h0000_0406);

        // Push into a full FIFO while the stream pops in the same cycle
        m_ready = 1'b1; reg_wr_en = 1'b1; reg_wr_addr = A_TX; reg_wr_data = 32'h9;
        @(negedge ACLK);
        m_ready = 1'b0; reg_wr_en = 1'b0;
        reg_read(A_ST, d); chk("status_push_pop_full", d, 32'h0000_0406);
        m_ready = 1'b1;
        chk("tx_seq0", m_data, 32'h12); @(negedge ACLK);
        chk("tx_seq1", m_data, 32'h13); @(negedge ACLK);
        chk("tx_seq2", m_data, 32'h14); @(negedge ACLK);
        chk("tx_seq3", m_data, 32'h09); @(negedge ACLK);
        m_ready = 1'b0;
        chk("tx_seq_done", {31'b0, m_valid}, 32'd0);

        // RX fill with irq enabled, then drain through RXDATA
        reg_write(A_CT, 32'h4);
        reg_read(A_CT, d); chk("ctrl_readback", d, 32'h4);
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 32'hA0 + 32'(i);
            @(negedge ACLK);
            if (i == 0) chk("irq_not_yet", {31'b0, irq}, 32'd0);
            if (i == 1) chk("irq_raised", {31'b0, irq}, 32'd1);
        end
        s_valid = 1'b0;
        chk("rx_full_s_ready", {31'b0, s_ready}, 32'd0);
        reg_read(A_ST, d); chk("status_rx_full", d, 32'h0004_0009);
        for (int i = 0; i < 4; i++) begin
            reg_read(A_RX, d); chk("rx_data", d, 32'hA0 + 32'(i));
        end
        chk("irq_before_fall", {31'b0, irq}, 32'd1);
        @(negedge ACLK);
        chk("irq_fallen", {31'b0, irq}, 32'd0);
        chk("rd_valid_pulse", {31'b0, reg_rd_valid}, 32'd0);

        // Underflow
        reg_read(A_RX, d); chk("rx_udf_data", d, 32'd0);
        reg_read(A_ST, d); chk("status_rx_udf", d, 32'h0000_0025);
        // Clear and new underflow in the same cycle: set wins
        reg_wr_en = 1'b1; reg_wr_addr = A_ST; reg_wr_data = 32'h20;
        reg_rd_en = 1'b1; reg_rd_addr = A_RX;
        @(negedge ACLK);
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        chk("udf_race_valid", {31'b0, reg_rd_valid}, 32'd1);
        chk("udf_race_data", reg_rd_data, 32'd0);
        reg_read(A_ST, d); chk("status_set_wins", d, 32'h0000_0025);
        reg_write(A_ST, 32'h20);
        reg_read(A_ST, d); chk("status_udf_cleared", d, 32'h0000_0005);

        // RX flush during an incoming beat
        s_valid = 1'b1; s_data = 32'hB0; @(negedge ACLK);
        s_data = 32'hB1; @(negedge ACLK);
        s_valid = 1'b0;
        reg_read(A_ST, d); chk("status_rx_two", d, 32'h0002_0001);
        chk("irq_rx_two", {31'b0, irq}, 32'd1);
        s_valid = 1'b1; s_data = 32'hB2;
        reg_write(A_CT, 32'h2);
        s_valid = 1'b0;
        reg_read(A_ST, d); chk("status_after_flush", d, 32'h0000_0005);
        chk("irq_after_flush", {31'b0, irq}, 32'd0);

        // Asynchronous reset mid-stream, with a read response in flight
        reg_write(A_CT, 32'h4);
        reg_write(A_TX, 32'h77);
        s_valid = 1'b1; s_data = 32'hC0; @(negedge ACLK);
        s_valid = 1'b0; @(negedge ACLK);
        chk("pre_rst_irq", {31'b0, irq}, 32'd1);
        chk("pre_rst_m_data", m_data, 32'h77);
        s_valid = 1'b1; s_data = 32'hC1;
        reg_rd_en = 1'b1; reg_rd_addr = A_ST;
        @(posedge ACLK); #1;
        reg_rd_en = 1'b0;
        chk("pre_rst_rd_valid", {31'b0, reg_rd_valid}, 32'd1);
        ARESET = 1'b1; s_valid = 1'b0;
        #1;
        chk("mid_rst_rd_valid", {31'b0, reg_rd_valid}, 32'd0);
        chk("mid_rst_rd_data", reg_rd_data, 32'd0);
        chk("mid_rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("mid_rst_m_data", m_data, 32'd0);
        chk("mid_rst_s_ready", {31'b0, s_ready}, 32'd1);
        chk("mid_rst_irq", {31'b0, irq}, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        reg_read(A_ST, d); chk("status_post_rst", d, 32'h0000_0005);
        reg_read(A_CT, d); chk("ctrl_post_rst", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
